pc_gen_multi: RTL

- Parametrised fetch-PC generator. Successor to the single-issue PC register.
- Produces one aligned fetch block of up to FETCH_WIDTH instructions per cycle, with a per-slot valid mask and ADEF/interrupt tags.
- Uses a valid/ready handshake toward the I-cache.
- Sits at the head of the front end; it is driven by the BPU, the branch-resolution unit and the CSR/exception controller.

---
 rtl/pc_gen_multi_pkg.sv | 42 ++++
 rtl/fetch_mask_gen.sv | 17 +
 rtl/pc_gen_multi.sv | 108 ++++++++++
 3 files changed

// File: rtl/pc_gen_multi_pkg.sv
// Shared front-end pipeline types: fetch-block payload, exception codes and block-mask helpers.
package pc_gen_multi_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_FETCH_WIDTH = 2;
  localparam logic [31:0] DEF_RESET_PC    = 32'h1C00_0000;

  localparam logic [5:0] EXCEPTION_INT  = 6'h00;
  localparam logic [5:0] EXCEPTION_ADEF = 6'h08;

  function automatic int unsigned fetch_bytes(input int unsigned fw);
    return 4 * fw;
  endfunction

  function automatic int unsigned off_width(input int unsigned fw);
    return $clog2(fw);
  endfunction

  localparam int unsigned FETCH_BYTES = fetch_bytes(DEF_FETCH_WIDTH);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]      pc;
    logic [DEF_FETCH_WIDTH-1:0] slot_valid;
    logic                       exc_adef;
    logic                       exc_int;
  } pc_out_t;

  // Lanes from the start slot to the block end; a misaligned pc keeps only its own slot.
  function automatic logic [7:0] block_mask(input int unsigned fw, input logic [4:0] low);
    int unsigned off;
    logic [7:0]  m;
    off = 32'(low[4:2]) & (fw - 32'd1);
    m   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < fw) begin
        m[i] = (low[1:0] != 2'b00) ? (i == off) : (i >= off);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_mask_gen.sv
// Combinational block-offset decode: low pc bits to per-slot valid mask and misalign flag.
module fetch_mask_gen
  import pc_gen_multi_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH
) (
  input  logic [off_width(FETCH_WIDTH)+1:0] pc_low_i,
  output logic [FETCH_WIDTH-1:0]            slot_valid_c,
  output logic                              misalign_c
);

  always_comb begin
    slot_valid_c = FETCH_WIDTH'(block_mask(FETCH_WIDTH, 5'(pc_low_i)));
    misalign_c   = (pc_low_i[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_gen_multi.sv
// Fetch-PC generator: one aligned fetch block per accepted request, redirected by flushes and the BPU.
module pc_gen_multi
  import pc_gen_multi_pkg::*;
#(
  parameter int unsigned       FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   pause,
  input  logic                   exc_flush,
  input  logic [ADDR_W-1:0]      exc_pc,
  input  logic                   br_flush,
  input  logic [ADDR_W-1:0]      br_pc,
  input  logic                   pre_taken,
  input  logic [ADDR_W-1:0]      pre_pc,
  input  logic                   is_interrupt,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [ADDR_W-1:0]      pc,
  output logic [FETCH_WIDTH-1:0] slot_valid,
  output logic                   exc_adef,
  output logic                   exc_int
);

  localparam int unsigned OFF_W = off_width(FETCH_WIDTH);
  localparam int unsigned BLK_W = OFF_W + 2;
  localparam logic [FETCH_WIDTH-1:0] RESET_MASK =
    FETCH_WIDTH'(block_mask(FETCH_WIDTH, 5'(RESET_PC[BLK_W-1:0])));

  typedef struct packed {
    logic [ADDR_W-1:0]      pc;
    logic [FETCH_WIDTH-1:0] slot_valid;
    logic                   exc_adef;
    logic                   exc_int;
  } blk_t;

  blk_t                   blk_q, blk_d;
  logic                   fetch_valid_q;
  logic                   accept;
  logic                   load;
  logic [ADDR_W-1:0]      nxt_pc;
  logic [ADDR_W-1:0]      seq_pc;
  logic [FETCH_WIDTH-1:0] nxt_mask;
  logic                   nxt_adef;

  assign accept = fetch_valid_q & fetch_ready;
  assign seq_pc = {blk_q.pc[ADDR_W-1:BLK_W], {BLK_W{1'b0}}}
                + ADDR_W'(fetch_bytes(FETCH_WIDTH));

  // Redirect priority: exception, mispredict, stall/pause hold, handshake hold, prediction, sequential.
  always_comb begin
    nxt_pc = blk_q.pc;
    load   = 1'b0;
    if (exc_flush) begin
      nxt_pc = exc_pc;
      load   = 1'b1;
    end else if (br_flush) begin
      nxt_pc = br_pc;
      load   = 1'b1;
    end else if (stall || pause) begin
      load   = 1'b0;
    end else if (accept) begin
      nxt_pc = pre_taken ? pre_pc : seq_pc;
      load   = 1'b1;
    end
  end

  fetch_mask_gen #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_mask (
    .pc_low_i     (nxt_pc[BLK_W-1:0]),
    .slot_valid_c (nxt_mask),
    .misalign_c   (nxt_adef)
  );

  always_comb begin
    blk_d = blk_q;
    if (load) begin
      blk_d.pc         = nxt_pc;
      blk_d.slot_valid = nxt_mask;
      blk_d.exc_adef   = nxt_adef;
      blk_d.exc_int    = is_interrupt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q    <= 1'b0;
      blk_q.pc         <= RESET_PC;
      blk_q.slot_valid <= RESET_MASK;
      blk_q.exc_adef   <= 1'b0;
      blk_q.exc_int    <= 1'b0;
    end else begin
      fetch_valid_q    <= 1'b1;
      blk_q            <= blk_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc          = blk_q.pc;
  assign slot_valid  = blk_q.slot_valid;
  assign exc_adef    = blk_q.exc_adef;
  assign exc_int     = blk_q.exc_int;

endmodule
